// File: rtl/bigword_cache.sv
// Single-line read cache in front of the packet memory read port.
// Hits and misses both return exactly MEM_LAT cycles after rd_en.
module bigword_cache #(
    parameter int ADDR_WIDTH        = 10,
    parameter int SN_FWD_DATA_WIDTH = 64,
    parameter int MEM_LAT           = 1,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:0]        word_rd_addra,
    input  logic                         rd_en,
    input  logic                         inval,
    output logic [SN_FWD_DATA_WIDTH-1:0] bigword,
    output logic                         bigword_vld,
    output logic [ADDR_WIDTH-1:0]        mem_rd_addr,
    output logic                         mem_rd_en,
    input  logic [SN_FWD_DATA_WIDTH-1:0] mem_rdata,
    input  logic                         mem_rdata_vld,
    output logic [CNT_WIDTH-1:0]         hit_cnt,
    output logic [CNT_WIDTH-1:0]         miss_cnt,
    output logic                         lat_err
);

    localparam int LAST = MEM_LAT - 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                         line_vld;
    logic [ADDR_WIDTH-1:0]        line_tag;
    logic [SN_FWD_DATA_WIDTH-1:0] line_data;

    logic                         p_vld  [MEM_LAT];
    logic                         p_hit  [MEM_LAT];
    logic                         p_kill [MEM_LAT];
    logic [ADDR_WIDTH-1:0]        p_tag  [MEM_LAT];
    logic [SN_FWD_DATA_WIDTH-1:0] p_data [MEM_LAT];

    logic fill_pending;
    logic hit;
    logic ret_miss;
    logic fill;

    // Any live fill in the pipe means the line is about to change, so no hits meanwhile.
    always_comb begin
        fill_pending = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) begin
            fill_pending = fill_pending | (p_vld[i] & ~p_hit[i] & ~p_kill[i]);
        end
    end

    assign hit         = line_vld && (line_tag == word_rd_addra) && !inval && !fill_pending;
    assign mem_rd_en   = rst_n && rd_en && !hit;
    assign mem_rd_addr = rst_n ? word_rd_addra : '0;

    assign ret_miss    = p_vld[LAST] && !p_hit[LAST];
    assign fill        = ret_miss && !p_kill[LAST] && !inval;
    assign bigword_vld = p_vld[LAST];
    assign bigword     = !p_vld[LAST] ? '0 : (p_hit[LAST] ? p_data[LAST] : mem_rdata);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld[0]  <= 1'b0;
            p_hit[0]  <= 1'b0;
            p_kill[0] <= 1'b0;
            p_tag[0]  <= '0;
            p_data[0] <= '0;
        end else begin
            p_vld[0]  <= rd_en;
            p_hit[0]  <= rd_en && hit;
            p_kill[0] <= 1'b0;
            p_tag[0]  <= word_rd_addra;
            p_data[0] <= line_data;
        end
    end

    // Slots already in flight when inval arrives pick up kill as they advance.
    for (genvar s = 1; s < MEM_LAT; s++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p_vld[s]  <= 1'b0;
                p_hit[s]  <= 1'b0;
                p_kill[s] <= 1'b0;
                p_tag[s]  <= '0;
                p_data[s] <= '0;
            end else begin
                p_vld[s]  <= p_vld[s-1];
                p_hit[s]  <= p_hit[s-1];
                p_kill[s] <= p_kill[s-1] | inval;
                p_tag[s]  <= p_tag[s-1];
                p_data[s] <= p_data[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_vld  <= 1'b0;
            line_tag  <= '0;
            line_data <= '0;
        end else if (inval) begin
            line_vld  <= 1'b0;
        end else if (fill) begin
            line_vld  <= 1'b1;
            line_tag  <= p_tag[LAST];
            line_data <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            lat_err  <= 1'b0;
        end else begin
            if (rd_en && hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + CNT_ONE;
            end
            if (rd_en && !hit && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + CNT_ONE;
            end
            if (ret_miss && !mem_rdata_vld) begin
                lat_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bigword_cache.sv
// Directed bench for bigword_cache: a MEM_LAT=1 unit and a MEM_LAT=2 / CNT_WIDTH=4 unit.
module tb_bigword_cache;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem_xor;
    int errors = 0;
    int checks = 0;

    logic        a_rd_en, a_inval, a_novld;
    logic [9:0]  a_addr, a_mem_rd_addr;
    logic [63:0] a_bigword, a_mem_rdata;
    logic        a_bigword_vld, a_mem_rd_en, a_mem_rdata_vld, a_lat_err;
    logic [31:0] a_hit_cnt, a_miss_cnt;

    logic        b_rd_en, b_inval;
    logic [9:0]  b_addr, b_mem_rd_addr;
    logic [63:0] b_bigword, b_mem_rdata, b_d1_rdata;
    logic        b_bigword_vld, b_mem_rd_en, b_mem_rdata_vld, b_d1_vld, b_lat_err;
    logic [3:0]  b_hit_cnt, b_miss_cnt;

    bigword_cache #(.ADDR_WIDTH(10), .SN_FWD_DATA_WIDTH(64), .MEM_LAT(1), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .word_rd_addra(a_addr), .rd_en(a_rd_en), .inval(a_inval),
        .bigword(a_bigword), .bigword_vld(a_bigword_vld), .mem_rd_addr(a_mem_rd_addr),
        .mem_rd_en(a_mem_rd_en), .mem_rdata(a_mem_rdata), .mem_rdata_vld(a_mem_rdata_vld),
        .hit_cnt(a_hit_cnt), .miss_cnt(a_miss_cnt), .lat_err(a_lat_err)
    );

    bigword_cache #(.ADDR_WIDTH(10), .SN_FWD_DATA_WIDTH(64), .MEM_LAT(2), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .word_rd_addra(b_addr), .rd_en(b_rd_en), .inval(b_inval),
        .bigword(b_bigword), .bigword_vld(b_bigword_vld), .mem_rd_addr(b_mem_rd_addr),
        .mem_rd_en(b_mem_rd_en), .mem_rdata(b_mem_rdata), .mem_rdata_vld(b_mem_rdata_vld),
        .hit_cnt(b_hit_cnt), .miss_cnt(b_miss_cnt), .lat_err(b_lat_err)
    );

    function automatic logic [63:0] mem_word(input logic [9:0] addr);
        logic [63:0] base;
        base = (addr == 10'h005) ? 64'h1122334455667788 : (64'hDEAD_BEEF_0000_0000 | {54'd0, addr});
        return base ^ mem_xor;
    endfunction

    // Packet memory stand-ins; unrequested cycles return junk so hits must come from the line.
    always @(posedge clk) begin
        a_mem_rdata     <= a_mem_rd_en ? mem_word(a_mem_rd_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
        a_mem_rdata_vld <= a_mem_rd_en & ~a_novld;
        b_d1_rdata      <= b_mem_rd_en ? mem_word(b_mem_rd_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
        b_d1_vld        <= b_mem_rd_en;
        b_mem_rdata     <= b_d1_rdata;
        b_mem_rdata_vld <= b_d1_vld;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int unit, input logic rd, input logic [9:0] addr, input logic inv);
        @(negedge clk);
        if (unit == 0) begin
            a_rd_en = rd; a_addr = addr; a_inval = inv;
        end else begin
            b_rd_en = rd; b_addr = addr; b_inval = inv;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        a_rd_en = 1'b1; a_addr = 10'h3FF; a_inval = 1'b0; a_novld = 1'b0;
        b_rd_en = 1'b0; b_addr = 10'h000; b_inval = 1'b0;
        mem_xor = 64'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_vld",      {63'd0, a_bigword_vld}, 64'd0);
        checkOutput("rst_data",     a_bigword, 64'd0);
        checkOutput("rst_mem_en",   {63'd0, a_mem_rd_en}, 64'd0);
        checkOutput("rst_mem_addr", {54'd0, a_mem_rd_addr}, 64'd0);
        checkOutput("rst_hit_cnt",  {32'd0, a_hit_cnt}, 64'd0);
        checkOutput("rst_miss_cnt", {32'd0, a_miss_cnt}, 64'd0);
        checkOutput("rst_lat_err",  {63'd0, a_lat_err}, 64'd0);
        @(negedge clk);
        a_rd_en = 1'b0; a_addr = 10'h000; rst_n = 1'b1;

        // Miss then hit on the same word, three cycles apart
        applyStimulus(0, 1'b1, 10'h005, 1'b0);
        checkOutput("t1_miss_en",   {63'd0, a_mem_rd_en}, 64'd1);
        checkOutput("t1_miss_addr", {54'd0, a_mem_rd_addr}, 64'h005);
        applyStimulus(0, 1'b0, 10'h000, 1'b0);
        checkOutput("t1_ret1_vld",  {63'd0, a_bigword_vld}, 64'd1);
        checkOutput("t1_ret1_data", a_bigword, 64'h1122334455667788);
        applyStimulus(0, 1'b0, 10'h000, 1'b0);
        applyStimulus(0, 1'b1, 10'h005, 1'b0);
        checkOutput("t1_hit_en",    {63'd0, a_mem_rd_en}, 64'd0);
        applyStimulus(0, 1'b0, 10'h000, 1'b0);
        checkOutput("t1_ret2_vld",  {63'd0, a_bigword_vld}, 64'd1);
        checkOutput("t1_ret2_data", a_bigword, 64'h1122334455667788);
        checkOutput("t1_hit_cnt",   {32'd0, a_hit_cnt}, 64'd1);
        checkOutput("t1_miss_cnt",  {32'd0, a_miss_cnt}, 64'd1);

        // Back-to-back 5,6,5 from a cold line: all misses
        applyStimulus(0, 1'b0, 10'h000, 1'b1);
        applyStimulus(0, 1'b1, 10'h005, 1'b0);
        checkOutput("t2_en0",   {63'd0, a_mem_rd_en}, 64'd1);
        applyStimulus(0, 1'b1, 10'h006, 1'b0);
        checkOutput("t2_en1",   {63'd0, a_mem_rd_en}, 64'd1);
        checkOutput("t2_data0", a_bigword, 64'h1122334455667788);
        applyStimulus(0, 1'b1, 10'h005, 1'b0);
        checkOutput("t2_en2",   {63'd0, a_mem_rd_en}, 64'd1);
        checkOutput("t2_data1", a_bigword, 64'hDEAD_BEEF_0000_0006);
        applyStimulus(0, 1'b0, 10'h000, 1'b0);
        checkOutput("t2_vld2",  {63'd0, a_bigword_vld}, 64'd1);
        checkOutput("t2_data2", a_bigword, 64'h1122334455667788);
        checkOutput("t2_miss_cnt", {32'd0, a_miss_cnt}, 64'd4);
        checkOutput("t2_hit_cnt",  {32'd0, a_hit_cnt}, 64'd1);

        // Invalidate, refill with new contents, then hit
        applyStimulus(0, 1'b0, 10'h000, 1'b1);
        mem_xor = 64'h00FF_00FF_00FF_00FF;
        applyStimulus(0, 1'b1, 10'h005, 1'b0);
        checkOutput("t3_miss_en", {63'd0, a_mem_rd_en}, 64'd1);
        applyStimulus(0, 1'b0, 10'h000, 1'b0);
        checkOutput("t3_refill_data", a_bigword, 64'h11DD_33BB_5599_7777);
        applyStimulus(0, 1'b1, 10'h005, 1'b0);
        checkOutput("t3_hit_en", {63'd0, a_mem_rd_en}, 64'd0);
        applyStimulus(0, 1'b0, 10'h000, 1'b0);
        checkOutput("t3_hit_vld",  {63'd0, a_bigword_vld}, 64'd1);
        checkOutput("t3_hit_data", a_bigword, 64'h11DD_33BB_5599_7777);

        // rd_en together with inval: forced miss whose fill still installs
        mem_xor = 64'hFFFF_0000_FFFF_0000;
        applyStimulus(0, 1'b1, 10'h005, 1'b1);
        checkOutput("t3b_forced_miss", {63'd0, a_mem_rd_en}, 64'd1);
        applyStimulus(0, 1'b0, 10'h000, 1'b0);
        checkOutput("t3b_data", a_bigword, 64'hEEDD_3344_AA99_7788);
        applyStimulus(0, 1'b1, 10'h005, 1'b0);
        checkOutput("t3b_hit_en", {63'd0, a_mem_rd_en}, 64'd0);
        applyStimulus(0, 1'b0, 10'h000, 1'b0);
        checkOutput("t3b_hit_data", a_bigword, 64'hEEDD_3344_AA99_7788);
        checkOutput("t3b_hit_cnt",  {32'd0, a_hit_cnt}, 64'd3);
        checkOutput("t3b_miss_cnt", {32'd0, a_miss_cnt}, 64'd6);

        // Missing mem_rdata_vld on a miss return sets sticky lat_err
        mem_xor = 64'd0;
        a_novld = 1'b1;
        applyStimulus(0, 1'b1, 10'h007, 1'b0);
        applyStimulus(0, 1'b0, 10'h000, 1'b0);
        a_novld = 1'b0;
        checkOutput("t5_vld",  {63'd0, a_bigword_vld}, 64'd1);
        checkOutput("t5_data", a_bigword, 64'hDEAD_BEEF_0000_0007);
        checkOutput("t5_no_err_yet", {63'd0, a_lat_err}, 64'd0);
        applyStimulus(0, 1'b0, 10'h000, 1'b0);
        checkOutput("t5_err_set", {63'd0, a_lat_err}, 64'd1);
        applyStimulus(0, 1'b1, 10'h008, 1'b0);
        applyStimulus(0, 1'b0, 10'h000, 1'b0);
        applyStimulus(0, 1'b0, 10'h000, 1'b0);
        checkOutput("t5_err_sticky", {63'd0, a_lat_err}, 64'd1);

        // Reset with a miss in flight
        applyStimulus(0, 1'b1, 10'h009, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_vld",      {63'd0, a_bigword_vld}, 64'd0);
        checkOutput("t6_data",     a_bigword, 64'd0);
        checkOutput("t6_mem_en",   {63'd0, a_mem_rd_en}, 64'd0);
        checkOutput("t6_hit_cnt",  {32'd0, a_hit_cnt}, 64'd0);
        checkOutput("t6_miss_cnt", {32'd0, a_miss_cnt}, 64'd0);
        checkOutput("t6_lat_err",  {63'd0, a_lat_err}, 64'd0);
        @(negedge clk);
        a_rd_en = 1'b0; a_addr = 10'h000; rst_n = 1'b1;
        #1;
        checkOutput("t6_post_vld0", {63'd0, a_bigword_vld}, 64'd0);
        applyStimulus(0, 1'b0, 10'h000, 1'b0);
        checkOutput("t6_post_vld1", {63'd0, a_bigword_vld}, 64'd0);

        // MEM_LAT=2: inval kills an in-flight miss's fill but data still returns
        applyStimulus(1, 1'b1, 10'h010, 1'b0);
        checkOutput("t4_miss_en", {63'd0, b_mem_rd_en}, 64'd1);
        applyStimulus(1, 1'b0, 10'h000, 1'b1);
        applyStimulus(1, 1'b0, 10'h000, 1'b0);
        checkOutput("t4_killed_vld",  {63'd0, b_bigword_vld}, 64'd1);
        checkOutput("t4_killed_data", b_bigword, 64'hDEAD_BEEF_0000_0010);
        applyStimulus(1, 1'b0, 10'h000, 1'b0);
        applyStimulus(1, 1'b1, 10'h010, 1'b0);
        checkOutput("t4_no_fill_miss", {63'd0, b_mem_rd_en}, 64'd1);
        applyStimulus(1, 1'b0, 10'h000, 1'b0);
        applyStimulus(1, 1'b0, 10'h000, 1'b0);
        checkOutput("t4_ret_data", b_bigword, 64'hDEAD_BEEF_0000_0010);
        applyStimulus(1, 1'b1, 10'h010, 1'b0);
        checkOutput("t4_hit_en", {63'd0, b_mem_rd_en}, 64'd0);

        // 20 further hits saturate the 4-bit hit counter
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1'b1, 10'h010, 1'b0);
        end
        applyStimulus(1, 1'b0, 10'h000, 1'b0);
        applyStimulus(1, 1'b0, 10'h000, 1'b0);
        checkOutput("t6b_hit_vld",  {63'd0, b_bigword_vld}, 64'd1);
        checkOutput("t6b_hit_data", b_bigword, 64'hDEAD_BEEF_0000_0010);
        checkOutput("t6b_hit_sat",  {60'd0, b_hit_cnt}, 64'hF);
        checkOutput("t6b_miss_cnt", {60'd0, b_miss_cnt}, 64'd2);
        checkOutput("t6b_lat_err",  {63'd0, b_lat_err}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
